// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronises sck/ws/sd to clk_i, deserialises each slot
// MSB-first and presents left/right words with one-cycle valid strobes.
module i2s_rx #(
  parameter int AUDIO_DW    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sck_i,
  input  logic                ws_i,
  input  logic                sd_i,
  output logic [AUDIO_DW-1:0] l_data_o,
  output logic [AUDIO_DW-1:0] r_data_o,
  output logic                l_valid_o,
  output logic                r_valid_o,
  output logic                short_o,
  output logic                locked_o
);

  localparam int CW = $clog2(AUDIO_DW + 1);

  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic                   sck_p0, ws_p0, sd_p0, sck_p1;
  logic                   sck_rise;

  logic                   primed;
  logic                   ws_last;
  logic [CW-1:0]          cnt;
  logic [AUDIO_DW-1:0]    shift;

  logic [AUDIO_DW-1:0]    shift_nxt;
  logic [CW-1:0]          cnt_nxt;
  logic                   short_nxt;

  // stage p0: synchroniser outputs; p1: previous synced sck for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_p1   <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_i};
      sck_p1   <= sck_p0;
    end
  end

  assign sck_p0   = sck_sync[SYNC_STAGES-1];
  assign ws_p0    = ws_sync[SYNC_STAGES-1];
  assign sd_p0    = sd_sync[SYNC_STAGES-1];
  assign sck_rise = sck_p0 & ~sck_p1;

  // Bit placement: once cnt saturates no position matches, so extra bits drop.
  always_comb begin
    shift_nxt = shift;
    for (int i = 0; i < AUDIO_DW; i++) begin
      if (int'(cnt) == AUDIO_DW - 1 - i) shift_nxt[i] = sd_p0;
    end
    cnt_nxt   = (cnt == CW'(AUDIO_DW)) ? cnt : cnt + CW'(1);
    short_nxt = (cnt_nxt != CW'(AUDIO_DW));
  end

  // stage p2: framing state and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      primed    <= 1'b0;
      ws_last   <= 1'b0;
      cnt       <= '0;
      shift     <= '0;
      l_data_o  <= '0;
      r_data_o  <= '0;
      l_valid_o <= 1'b0;
      r_valid_o <= 1'b0;
      short_o   <= 1'b0;
      locked_o  <= 1'b0;
    end else begin
      l_valid_o <= 1'b0;
      r_valid_o <= 1'b0;
      short_o   <= 1'b0;
      if (sck_rise) begin
        if (!primed) begin
          primed  <= 1'b1;
          ws_last <= ws_p0;
        end else if (ws_p0 != ws_last) begin
          // The transition edge carries the LSB of the slot being closed.
          if (locked_o) begin
            if (!ws_last) begin
              l_data_o  <= shift_nxt;
              l_valid_o <= 1'b1;
            end else begin
              r_data_o  <= shift_nxt;
              r_valid_o <= 1'b1;
            end
            short_o <= short_nxt;
          end
          shift    <= '0;
          cnt      <= '0;
          ws_last  <= ws_p0;
          locked_o <= 1'b1;
        end else begin
          shift <= shift_nxt;
          cnt   <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a behavioural I2S transmitter feeds slot streams while a
// scoreboard matches every valid strobe against the expected word queue.
module tb_i2s_rx;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       sck_i, ws_i, sd_i;
  logic [7:0] l_data_o, r_data_o;
  logic       l_valid_o, r_valid_o, short_o, locked_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         ch;
    logic [7:0] data;
    bit         shrt;
  } exp_t;

  exp_t exp_q[$];
  bit   ws_q[$];
  bit   sd_q[$];
  exp_t e;

  always #5 clk = ~clk;

  i2s_rx #(.AUDIO_DW(8), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .sck_i     (sck_i),
    .ws_i      (ws_i),
    .sd_i      (sd_i),
    .l_data_o  (l_data_o),
    .r_data_o  (r_data_o),
    .l_valid_o (l_valid_o),
    .r_valid_o (r_valid_o),
    .short_o   (short_o),
    .locked_o  (locked_o)
  );

  // Scoreboard: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_ni === 1'b1 && (l_valid_o === 1'b1 || r_valid_o === 1'b1)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe l_valid=%0b r_valid=%0b l=%h r=%h required no strobe",
                 l_valid_o, r_valid_o, l_data_o, r_data_o);
      end else begin
        e = exp_q.pop_front();
        if ((l_valid_o && r_valid_o) || (r_valid_o !== e.ch) ||
            ((r_valid_o ? r_data_o : l_data_o) !== e.data) || (short_o !== e.shrt)) begin
          bad++;
          $display("FAIL strobe got ch=%0b data=%h short=%0b required ch=%0b data=%h short=%0b",
                   r_valid_o, (r_valid_o ? r_data_o : l_data_o), short_o, e.ch, e.data, e.shrt);
        end
      end
    end
  end

  // Queue one slot of n bits (MSB first); expect a commit when exp is set.
  task automatic add_slot(input bit ws, input int n, input logic [63:0] word, input bit exp);
    exp_t x;
    for (int i = n - 1; i >= 0; i--) begin
      ws_q.push_back(ws);
      sd_q.push_back(word[i]);
    end
    if (exp) begin
      x.ch   = ws;
      x.data = (n >= 8) ? word[n-1 -: 8] : 8'(word << (8 - n));
      x.shrt = (n < 8);
      exp_q.push_back(x);
    end
  endtask

  // Transmitter: ws leads the slot by one bit; sck = clk/8.
  task automatic play(input int from, input int to);
    for (int k = from; k < to; k++) begin
      sck_i = 1'b0;
      ws_i  = (k + 1 < ws_q.size()) ? ws_q[k+1] : ws_q[k];
      sd_i  = sd_q[k];
      repeat (4) @(negedge clk);
      sck_i = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    sck_i  = 1'b0;
    ws_i   = 1'b0;
    sd_i   = 1'b0;
    exp_q.delete();
    ws_q.delete();
    sd_q.delete();
    repeat (4) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({l_data_o, r_data_o, l_valid_o, r_valid_o, short_o, locked_o} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs l=%h r=%h lv=%0b rv=%0b sh=%0b lk=%0b required all 0",
               l_data_o, r_data_o, l_valid_o, r_valid_o, short_o, locked_o);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 7; i++)
      add_slot(i[0], 8, i[0] ? 64'h3C : 64'hA5, i != 0 && i != 6);
    play(0, 8);
    total++;
    if (locked_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_locked got=%0b required 1", locked_o);
    end
    play(8, ws_q.size());
    drain("basic");
  endtask

  task automatic test_long_slot();
    do_reset();
    for (int i = 0; i < 5; i++)
      add_slot(i[0], 16, i[0] ? 64'hFFFF : 64'h12F0, i != 0 && i != 4);
    play(0, ws_q.size());
    drain("long");
  endtask

  task automatic test_short_slot();
    do_reset();
    for (int i = 0; i < 5; i++)
      add_slot(i[0], 5, i[0] ? 64'h0B : 64'h16, i != 0 && i != 4);
    play(0, ws_q.size());
    drain("short");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++)
      add_slot(i[0], 8, i[0] ? 64'h3C : 64'hA5, i == 1 || i == 2 || i == 4 || i == 5);
    play(0, 28);
    rst_ni = 1'b0;
    @(negedge clk);
    total++;
    if ({l_data_o, r_data_o, l_valid_o, r_valid_o, short_o, locked_o} !== 20'h0) begin
      bad++;
      $display("FAIL midreset_outputs l=%h r=%h lk=%0b required all 0", l_data_o, r_data_o, locked_o);
    end
    rst_ni = 1'b1;
    play(28, ws_q.size());
    drain("midreset");
  endtask

  task automatic test_ws_stuck();
    logic [63:0] rnd, rw;
    do_reset();
    rnd = {24'h0, 8'($urandom), $urandom};
    rw  = 64'($urandom_range(0, 255));
    add_slot(1'b0, 8, 64'h5A, 1'b0);
    add_slot(1'b1, 8, 64'h3C, 1'b1);
    add_slot(1'b0, 40, rnd, 1'b1);
    add_slot(1'b1, 8, rw, 1'b1);
    add_slot(1'b0, 8, 64'h00, 1'b0);
    play(0, 40);
    total++;
    if (l_data_o !== 8'h00 || r_data_o !== 8'h3C) begin
      bad++;
      $display("FAIL stuck_hold l=%h r=%h required l=00 r=3c", l_data_o, r_data_o);
    end
    play(40, ws_q.size());
    drain("stuck");
  endtask

  task automatic test_loopback();
    logic [7:0] lfsr;
    do_reset();
    lfsr = 8'h1D;
    add_slot(1'b1, 8, 64'hC3, 1'b0);
    for (int f = 0; f < 100; f++) begin
      if (f == 0) begin
        add_slot(1'b0, 8, 64'h55, 1'b1);
        add_slot(1'b1, 8, 64'hAA, 1'b1);
      end else begin
        for (int s = 0; s < 2; s++) begin
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          add_slot(s[0], 8, {56'h0, lfsr}, 1'b1);
        end
      end
    end
    add_slot(1'b0, 8, 64'h00, 1'b0);
    play(0, ws_q.size());
    drain("loopback");
  endtask

  initial begin
    rst_ni = 1'b0;
    sck_i  = 1'b0;
    ws_i   = 1'b0;
    sd_i   = 1'b0;
    test_reset();
    test_basic();
    test_long_slot();
    test_short_slot();
    test_reset_mid();
    test_ws_stuck();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
